// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm ringing block.
package alarm_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RINGING  = 2'd1,
    SNOOZE   = 2'd2,
    WAIT_CLR = 2'd3
  } alarm_state_e;

  localparam int DIGIT_W            = 4;
  localparam int HALF_TICKS_PER_SEC = 2;
  localparam int SEC_PER_MIN        = 60;

  typedef logic [DIGIT_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t hr_10;
    bcd_t hr_1;
    bcd_t min_10;
    bcd_t min_1;
  } hhmm_t;
endpackage

// File: rtl/alarm_trigger_if.sv
// Buttons, BCD time/alarm digits and buzzer status between the board and alarm_trigger.
interface alarm_trigger_if;
  import alarm_pkg::*;

  logic       alon;
  logic       stop_btn;
  logic       snooze_btn;
  bcd_t       min_1s, min_10s, hr_1s, hr_10s;
  bcd_t       min_1sa, min_10sa, hr_1sa, hr_10sa;
  logic       alarm1;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_cnt;

  modport master (
    output alon, stop_btn, snooze_btn,
    output min_1s, min_10s, hr_1s, hr_10s,
    output min_1sa, min_10sa, hr_1sa, hr_10sa,
    input  alarm1, ringing, snoozing, snooze_cnt
  );

  modport slave (
    input  alon, stop_btn, snooze_btn,
    input  min_1s, min_10s, hr_1s, hr_10s,
    input  min_1sa, min_10sa, hr_1sa, hr_10sa,
    output alarm1, ringing, snoozing, snooze_cnt
  );
endinterface

// File: rtl/button_edge.sv
// Raw button -> 3-flop synchroniser -> registered one-cycle rising-edge pulse.
module button_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);
  logic [2:0] sync;
  logic       last;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      last  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[1:0], btn};
      last  <= sync[2];
      pulse <= sync[2] & ~last;
    end
  end
endmodule

// File: rtl/alarm_trigger.sv
// Alarm match detect and ringing FSM (beep, stop, snooze, timeout).
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic            clk_100MHz,
  input  logic            reset,
  alarm_trigger_if.slave  bus
);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int RING_W = $clog2(HALF_TICKS_PER_SEC * RING_SECS);
  localparam int SNZ_W  = $clog2(SNOOZE_MIN * SEC_PER_MIN * HALF_TICKS_PER_SEC);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(HALF_TICKS_PER_SEC * RING_SECS - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_MIN * SEC_PER_MIN * HALF_TICKS_PER_SEC - 1);
  localparam logic [1:0]        MAX_SNZ   = 2'(MAX_SNOOZE);

  // Button lane 0 is stop; lane 1 (snooze) exists only in the snooze build.
`ifdef ALARM_SNOOZE_EN
  localparam int NUM_BTN = 2;
  logic [NUM_BTN-1:0] btn_raw;
  assign btn_raw = {bus.snooze_btn, bus.stop_btn};
`else
  localparam int NUM_BTN = 1;
  logic [NUM_BTN-1:0] btn_raw;
  assign btn_raw = bus.stop_btn;
`endif

  logic [NUM_BTN-1:0] btn_pulse;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    button_edge u_btn (
      .clk   (clk_100MHz),
      .reset (reset),
      .btn   (btn_raw[gi]),
      .pulse (btn_pulse[gi])
    );
  end

  logic stop_p, snz_p;
  assign stop_p = btn_pulse[0];
`ifdef ALARM_SNOOZE_EN
  assign snz_p = btn_pulse[1];
`else
  assign snz_p = 1'b0;
`endif

  logic [TICK_W-1:0] tick_q;
  logic              ht;
  assign ht = (tick_q == TICK_LAST);

  hhmm_t now_t, alm_t;
  logic  match, match_q, trig;
  assign now_t = {bus.hr_10s,  bus.hr_1s,  bus.min_10s,  bus.min_1s};
  assign alm_t = {bus.hr_10sa, bus.hr_1sa, bus.min_10sa, bus.min_1sa};
  assign match = bus.alon && (now_t == alm_t);
  assign trig  = match & ~match_q;

  alarm_state_e      state_q, state_d;
  logic [RING_W-1:0] ring_q, ring_d;
  logic [SNZ_W-1:0]  snz_q, snz_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              phase_q, phase_d;
  logic              alarm1_q, alarm1_d;

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!bus.alon) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (trig) begin
          state_d = RINGING;
          ring_d  = '0;
          phase_d = 1'b1;
          cnt_d   = '0;
        end
        RINGING: begin
          if (ht) begin
            phase_d = ~phase_q;
            ring_d  = ring_q + 1'b1;
          end
          // stop > snooze > timeout; a snooze past the limit acts as stop
          if (stop_p) state_d = WAIT_CLR;
          else if (snz_p) begin
            if (cnt_q < MAX_SNZ) begin
              state_d = SNOOZE;
              cnt_d   = cnt_q + 1'b1;
              snz_d   = '0;
            end else state_d = WAIT_CLR;
          end else if (ht && ring_q == RING_LAST) state_d = WAIT_CLR;
        end
        SNOOZE: begin
          if (ht) snz_d = snz_q + 1'b1;
          if (stop_p) state_d = WAIT_CLR;
          else if (ht && snz_q == SNZ_LAST) begin
            state_d = RINGING;
            ring_d  = '0;
            phase_d = 1'b1;
          end
        end
        WAIT_CLR: if (!match) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
    alarm1_d = (state_d == RINGING) && phase_d;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q  <= IDLE;
      ring_q   <= '0;
      snz_q    <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      alarm1_q <= 1'b0;
      match_q  <= 1'b0;
      tick_q   <= '0;
    end else begin
      state_q  <= state_d;
      ring_q   <= ring_d;
      snz_q    <= snz_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      alarm1_q <= alarm1_d;
      match_q  <= match;
      tick_q   <= ht ? '0 : tick_q + 1'b1;
    end
  end

  assign bus.alarm1  = alarm1_q;
  assign bus.ringing = (state_q == RINGING);
`ifdef ALARM_SNOOZE_EN
  assign bus.snoozing   = (state_q == SNOOZE);
  assign bus.snooze_cnt = cnt_q;
`else
  assign bus.snoozing   = 1'b0;
  assign bus.snooze_cnt = 2'b00;
`endif
endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger (TICK_DIV=4, RING_SECS=2, SNOOZE_MIN=1, MAX_SNOOZE=1).
module tb_alarm_trigger;
  logic clk_100MHz = 1'b0;
  logic reset      = 1'b1;
  int   checks     = 0;
  int   failures   = 0;

  alarm_trigger_if bus ();

  alarm_trigger #(
    .TICK_DIV   (4),
    .RING_SECS  (2),
    .SNOOZE_MIN (1),
    .MAX_SNOOZE (1)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One-cycle press on the raw button inputs
  task automatic press(input logic stop, input logic snz);
    bus.stop_btn   = stop;
    bus.snooze_btn = snz;
    tick(1);
    bus.stop_btn   = 1'b0;
    bus.snooze_btn = 1'b0;
  endtask

  // Leave WAIT_CLR via 07:31, then return to 07:30 to trigger a fresh ring
  task automatic rearm(input string tag);
    bus.min_1s = 4'd1;
    tick(2);
    bus.min_1s = 4'd0;
    tick(1);
    chk({tag, "_ring"}, bus.ringing, 1);
    chk({tag, "_cnt"}, bus.snooze_cnt, 0);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_alarm1"}, bus.alarm1, 0);
    chk({tag, "_ringing"}, bus.ringing, 0);
    chk({tag, "_snoozing"}, bus.snoozing, 0);
    chk({tag, "_cnt"}, bus.snooze_cnt, 0);
  endtask

  initial begin
    logic found;
    int   n;

    bus.alon = 1'b0; bus.stop_btn = 1'b0; bus.snooze_btn = 1'b0;
    bus.hr_10s = 4'd0;  bus.hr_1s = 4'd0;  bus.min_10s = 4'd0;  bus.min_1s = 4'd0;
    bus.hr_10sa = 4'd0; bus.hr_1sa = 4'd0; bus.min_10sa = 4'd0; bus.min_1sa = 4'd0;
    tick(2);
    chk_idle_outs("reset");

    // 07:30 time and alarm, alarm enabled
    reset = 1'b0;
    bus.hr_1s = 4'd7;  bus.min_10s = 4'd3;
    bus.hr_1sa = 4'd7; bus.min_10sa = 4'd3;
    bus.alon = 1'b1;
    chk("pre_match_ring", bus.ringing, 0);
    tick(1);
    chk("match_ring", bus.ringing, 1);
    chk("match_alarm1", bus.alarm1, 1);

    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick(1);
      if (bus.alarm1 == 1'b0) found = 1'b1;
    end
    chk("first_toggle_seen", found, 1);
    tick(3);  chk("hold_low", bus.alarm1, 0);
    tick(1);  chk("toggle_high", bus.alarm1, 1);
    tick(4);  chk("toggle_low", bus.alarm1, 0);
    tick(3);  chk("pre_timeout_ring", bus.ringing, 1);
    tick(1);
    chk("timeout_ring", bus.ringing, 0);
    chk("timeout_alarm1", bus.alarm1, 0);
    tick(10);
    chk("no_retrigger", bus.ringing, 0);

    // Stop: pulse after 4 cycles, state change one edge later
    rearm("rearm1");
    press(1'b1, 1'b0);
    tick(3);  chk("stop_pre", bus.ringing, 1);
    tick(1);
    chk("stop_ring", bus.ringing, 0);
    chk("stop_alarm1", bus.alarm1, 0);

    rearm("rearm2");
    press(1'b1, 1'b1);
    tick(4);
    chk("both_ring", bus.ringing, 0);
    chk("both_snoozing", bus.snoozing, 0);
    chk("both_cnt", bus.snooze_cnt, 0);

    rearm("rearm3");
`ifdef ALARM_SNOOZE_EN
    press(1'b0, 1'b1);
    tick(4);
    chk("snz_snoozing", bus.snoozing, 1);
    chk("snz_ring", bus.ringing, 0);
    chk("snz_cnt", bus.snooze_cnt, 1);
    chk("snz_alarm1", bus.alarm1, 0);
    found = 1'b0; n = 0;
    for (int i = 1; i <= 490 && !found; i++) begin
      tick(1);
      if (bus.ringing) begin found = 1'b1; n = i; end
    end
    chk("snz_return_seen", found, 1);
    chk("snz_return_len_ok", (n >= 477 && n <= 480), 1);
    chk("snz_return_alarm1", bus.alarm1, 1);
    press(1'b0, 1'b1);
    tick(4);
    chk("snz2_ring", bus.ringing, 0);
    chk("snz2_snoozing", bus.snoozing, 0);
    chk("snz2_cnt", bus.snooze_cnt, 1);
`else
    press(1'b0, 1'b1);
    tick(5);
    chk("nosnz_ring", bus.ringing, 1);
    chk("nosnz_snoozing", bus.snoozing, 0);
    chk("nosnz_cnt", bus.snooze_cnt, 0);
    tick(14);
    chk("nosnz_timeout", bus.ringing, 0);
`endif

    // Dropping alon kills the ring on the next edge
    rearm("rearm4");
    bus.alon = 1'b0;
    tick(1);
    chk("alon_ring", bus.ringing, 0);
    chk("alon_alarm1", bus.alarm1, 0);
    bus.alon = 1'b1;
    tick(1);
    chk("alon_retrig", bus.ringing, 1);

`ifdef ALARM_SNOOZE_EN
    press(1'b0, 1'b1);
    tick(4);
    chk("rst_pre_snoozing", bus.snoozing, 1);
`endif
    reset = 1'b1;
    tick(1);
    chk_idle_outs("midrst");
    reset = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
